// File: rtl/mem_banked_pkg.sv
// Shared constants, FSM state type and lane helper for the banked single-port memory.
package mem_banked_pkg;

  localparam int MACRO_DEPTH  = 512;
  localparam int MACRO_AWIDTH = 9;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } mem_state_e;

  // Bit offset of byte lane `lane` inside a data word.
  function automatic int lane_slice(input int lane);
    return lane * 8;
  endfunction

endpackage

// File: rtl/SRAM1RW512x8.sv
// Behavioural stand-in for the 512x8 single-port hard macro (active-low CSB/WEB/OEB).
module SRAM1RW512x8 (
  input  logic       CE,
  input  logic [8:0] A,
  input  logic [7:0] I,
  input  logic       CSB,
  input  logic       WEB,
  input  logic       OEB,
  output logic [7:0] O
);

  logic [7:0] mem [0:511];
  logic [7:0] dout_q;

  always_ff @(posedge CE) begin
    if (!CSB) begin
      if (!WEB) mem[A] <= I;
      else      dout_q <= mem[A];
    end
  end

  assign O = OEB ? 8'h00 : dout_q;

endmodule

// File: rtl/mem_banked_sp_row.sv
// One bank row: DATA_BYTES macros sharing chip select and address, one WEB per lane.
module mem_banked_sp_row
  import mem_banked_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                      clk_i,
  input  logic                      csb_i,
  input  logic [DATA_BYTES-1:0]     web_i,
  input  logic [MACRO_AWIDTH-1:0]   addr_i,
  input  logic [DATA_BYTES*8-1:0]   wdata_i,
  output logic [DATA_BYTES*8-1:0]   rdata_o
);

  for (genvar b = 0; b < DATA_BYTES; b++) begin : g_lane
    SRAM1RW512x8 u_sram (
      .CE  (clk_i),
      .A   (addr_i),
      .I   (wdata_i[lane_slice(b) +: 8]),
      .CSB (csb_i),
      .WEB (web_i[b]),
      .OEB (1'b0),
      .O   (rdata_o[lane_slice(b) +: 8])
    );
  end

endmodule

// File: rtl/mem_banked_sp_ctrl.sv
// Banked single-port memory controller: 1-cycle reads, byte-masked writes, read-data hold.
// Optional post-reset zero-clear sweep enabled by defining MEM_BANKED_CLEAR_EN.
module mem_banked_sp_ctrl
  import mem_banked_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int NBANKS     = DEPTH / MACRO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_BYTES-1:0] i_wen,
  output logic                  o_ready,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic                  o_init_done
);

  localparam int BANK_W = (ADDR_WIDTH > MACRO_AWIDTH) ? ADDR_WIDTH - MACRO_AWIDTH : 1;
`ifdef MEM_BANKED_CLEAR_EN
  localparam mem_state_e RESET_STATE = ST_CLEAR;
`else
  localparam mem_state_e RESET_STATE = ST_READY;
`endif

  mem_state_e state_q;
  logic       init_done_q;
`ifdef MEM_BANKED_CLEAR_EN
  logic [MACRO_AWIDTH-1:0] clr_cnt_q;
`endif

  logic                    fire, is_write, oor;
  logic [BANK_W-1:0]       req_bank, bank_q;
  logic                    rvalid_q, err_q;
  logic [DATA_WIDTH-1:0]   hold_q, rd_mux;

  logic [NBANKS-1:0]       row_csb;
  logic [DATA_BYTES-1:0]   row_web   [NBANKS];
  logic [DATA_WIDTH-1:0]   row_rdata [NBANKS];
  logic [MACRO_AWIDTH-1:0] row_addr;
  logic [DATA_WIDTH-1:0]   row_wdata;

  // Handshake: a request fires on i_req & o_ready; o_ready is never asserted during reset or clear.
  assign o_init_done = init_done_q & ~rst;
  assign o_ready     = o_init_done;
  assign fire        = i_req & o_ready;
  assign is_write    = |i_wen;
  assign req_bank    = BANK_W'(i_addr >> MACRO_AWIDTH);
  assign oor         = {1'b0, i_addr} >= (ADDR_WIDTH + 1)'(DEPTH);

  always_comb begin
    row_csb   = '1;
    row_addr  = i_addr[MACRO_AWIDTH-1:0];
    row_wdata = i_wdata;
    for (int r = 0; r < NBANKS; r++) row_web[r] = '1;
`ifdef MEM_BANKED_CLEAR_EN
    if (state_q == ST_CLEAR && !rst) begin
      row_csb   = '0;
      row_addr  = clr_cnt_q;
      row_wdata = '0;
      for (int r = 0; r < NBANKS; r++) row_web[r] = '0;
    end
`endif
    if (fire && !oor) begin
      for (int r = 0; r < NBANKS; r++) begin
        if (req_bank == BANK_W'(r)) begin
          row_csb[r] = 1'b0;
          row_web[r] = is_write ? ~i_wen : '1;
        end
      end
    end
  end

  for (genvar r = 0; r < NBANKS; r++) begin : g_row
    mem_banked_sp_row #(.DATA_BYTES(DATA_BYTES)) u_row (
      .clk_i   (clk),
      .csb_i   (row_csb[r]),
      .web_i   (row_web[r]),
      .addr_i  (row_addr),
      .wdata_i (row_wdata),
      .rdata_o (row_rdata[r])
    );
  end

  // Response mux is steered only by the registered bank, never the live address.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < NBANKS; r++) begin
      if (bank_q == BANK_W'(r)) rd_mux = row_rdata[r];
    end
    if (err_q) rd_mux = '0;
  end

  assign o_rdata  = rvalid_q ? rd_mux : hold_q;
  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= '0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= fire & ~is_write;
      err_q    <= fire & oor;
      bank_q   <= req_bank;
      if (rvalid_q) hold_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      init_done_q <= 1'b0;
`ifdef MEM_BANKED_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
`ifdef MEM_BANKED_CLEAR_EN
          clr_cnt_q <= clr_cnt_q + MACRO_AWIDTH'(1);
          if (clr_cnt_q == MACRO_AWIDTH'(MACRO_DEPTH - 1)) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
`else
          state_q     <= ST_READY;
          init_done_q <= 1'b1;
`endif
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_banked_sp_ctrl.sv
// Bench for mem_banked_sp_ctrl: word-level memory model checked every cycle plus directed literal checks.
module tb_mem_banked_sp_ctrl;

`ifdef MEM_BANKED_CLEAR_EN
  localparam int LAT = 512;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [10:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wen = '0;
  logic        o_ready, o_rvalid, o_err, o_init_done;
  logic [31:0] o_rdata;

  logic        s_req = 1'b0;
  logic [10:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wen = '0;
  logic        s_ready, s_rvalid, s_err, s_init_done;
  logic [31:0] s_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_banked_sp_ctrl #(.DATA_WIDTH(32), .DEPTH(2048)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_wdata(wdata), .i_wen(wen),
    .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
    .o_init_done(o_init_done)
  );

  mem_banked_sp_ctrl #(.DATA_WIDTH(32), .DEPTH(1536)) dut_s (
    .clk(clk), .rst(rst), .i_req(s_req), .i_addr(s_addr), .i_wdata(s_wdata), .i_wen(s_wen),
    .o_ready(s_ready), .o_rvalid(s_rvalid), .o_rdata(s_rdata), .o_err(s_err),
    .o_init_done(s_init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: word array with per-byte known flags; outputs follow from request rules.
  logic [31:0] m_mem   [2048];
  logic [3:0]  m_known [2048];
  int          since = 0;
  bit          armed = 1'b0;
  logic        exp_rvalid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0, exp_mask = '1;

  initial for (int i = 0; i < 2048; i++) m_known[i] = 4'h0;

  always @(posedge clk) begin
    bit m_fire;
    int a;
    m_fire = req && !rst && (since >= LAT);
    a = int'(addr);
    if (rst) begin
      since = 0; armed = 1'b1;
      exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_mask = '1;
    end else begin
      exp_rvalid = m_fire && (wen == 4'h0);
      exp_err    = 1'b0;
      if (m_fire && wen == 4'h0) begin
        exp_rdata = m_mem[a];
        for (int b = 0; b < 4; b++) exp_mask[8*b +: 8] = {8{m_known[a][b]}};
      end else if (m_fire) begin
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) begin
            m_mem[a][8*b +: 8] = wdata[8*b +: 8];
            m_known[a][b] = 1'b1;
          end
        end
      end
      since++;
`ifdef MEM_BANKED_CLEAR_EN
      if (since == LAT) for (int i = 0; i < 2048; i++) begin m_mem[i] = '0; m_known[i] = 4'hF; end
`endif
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_ready", {31'b0, o_ready}, {31'b0, !rst && since >= LAT});
      chk("cyc_init_done", {31'b0, o_init_done}, {31'b0, !rst && since >= LAT});
      chk("cyc_rvalid", {31'b0, o_rvalid}, {31'b0, exp_rvalid});
      chk("cyc_err", {31'b0, o_err}, {31'b0, exp_err});
      chk("cyc_rdata", o_rdata & exp_mask, exp_rdata & exp_mask);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_op(input logic [10:0] a, input logic [31:0] d, input logic [3:0] w);
    req = 1'b1; addr = a; wdata = d; wen = w;
    step();
    req = 1'b0; wen = 4'h0;
  endtask

  task automatic s_op(input logic [10:0] a, input logic [31:0] d, input logic [3:0] w);
    s_req = 1'b1; s_addr = a; s_wdata = d; s_wen = w;
    step();
    s_req = 1'b0; s_wen = 4'h0;
  endtask

  task automatic wait_init(input int exp_lat);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!o_init_done && c < 3000);
    chk("init_latency", 32'(c), 32'(exp_lat));
    chk("ready_after_init", {31'b0, o_ready}, 32'd1);
    chk("small_init_done", {31'b0, s_init_done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); step();
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_init_done", {31'b0, o_init_done}, 32'd0);
    chk("rst_rvalid", {31'b0, o_rvalid}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    rst = 1'b0;
    wait_init(LAT);

`ifdef MEM_BANKED_CLEAR_EN
    m_op(11'h000, '0, 4'h0); chk("clr_rd_0", o_rdata, 32'h0);
    m_op(11'h1FF, '0, 4'h0); chk("clr_rd_511", o_rdata, 32'h0);
    m_op(11'h600, '0, 4'h0); chk("clr_rd_1536", o_rdata, 32'h0);
    m_op(11'h7FF, '0, 4'h0); chk("clr_rd_2047", o_rdata, 32'h0);
`endif

    // Byte-masked write then immediate read of the same word
    m_op(11'h005, 32'hDEADBEEF, 4'hF);
    m_op(11'h005, 32'h000000AA, 4'h1);
    m_op(11'h005, '0, 4'h0);
    chk("mask_rvalid", {31'b0, o_rvalid}, 32'd1);
    chk("mask_rdata", o_rdata, 32'hDEADBEAA);

    m_op(11'h7FF, 32'hCAFEF00D, 4'hF);
    m_op(11'h7FF, 32'h00ABCD00, 4'h6);
    m_op(11'h7FF, '0, 4'h0);
    chk("top_word_rdata", o_rdata, 32'hCAABCD0D);

    // Back-to-back reads across banks
    m_op(11'h000, 32'h11111111, 4'hF);
    m_op(11'h600, 32'h33333333, 4'hF);
    m_op(11'h000, '0, 4'h0);
    chk("b2b_first", o_rdata, 32'h11111111);
    m_op(11'h600, '0, 4'h0);
    chk("b2b_second", o_rdata, 32'h33333333);
    chk("b2b_second_valid", {31'b0, o_rvalid}, 32'd1);
    step();
    chk("b2b_drop_valid", {31'b0, o_rvalid}, 32'd0);
    chk("b2b_hold", o_rdata, 32'h33333333);

    // Hold register through idle cycles and a write elsewhere
    m_op(11'h010, 32'h12345678, 4'hF);
    m_op(11'h010, '0, 4'h0);
    chk("hold_src", o_rdata, 32'h12345678);
    for (int i = 0; i < 5; i++) step();
    m_op(11'h420, 32'h0BADF00D, 4'hF);
    chk("hold_after_write", o_rdata, 32'h12345678);
    chk("hold_rvalid", {31'b0, o_rvalid}, 32'd0);

    // Out-of-range on the 1536-word build; row 0x100 aliases in every bank
    s_op(11'h100, 32'hA0A0A0A0, 4'hF);
    s_op(11'h300, 32'hB1B1B1B1, 4'hF);
    s_op(11'h500, 32'hC2C2C2C2, 4'hF);
    s_op(11'h500, '0, 4'h0);
    chk("s_rd_500", s_rdata, 32'hC2C2C2C2);
    s_op(11'h700, '0, 4'h0);
    chk("s_oor_rd_valid", {31'b0, s_rvalid}, 32'd1);
    chk("s_oor_rd_data", s_rdata, 32'h0);
    chk("s_oor_rd_err", {31'b0, s_err}, 32'd1);
    s_op(11'h700, 32'hFFFFFFFF, 4'hF);
    chk("s_oor_wr_err", {31'b0, s_err}, 32'd1);
    chk("s_oor_wr_valid", {31'b0, s_rvalid}, 32'd0);
    step();
    chk("s_err_clear", {31'b0, s_err}, 32'd0);
    s_op(11'h100, '0, 4'h0); chk("s_bank0_intact", s_rdata, 32'hA0A0A0A0);
    s_op(11'h300, '0, 4'h0); chk("s_bank1_intact", s_rdata, 32'hB1B1B1B1);
    s_op(11'h500, '0, 4'h0); chk("s_bank2_intact", s_rdata, 32'hC2C2C2C2);
    chk("s_inrange_err", {31'b0, s_err}, 32'd0);

    // Reset arriving with a read request drops it
    req = 1'b1; addr = 11'h005; wen = 4'h0; rst = 1'b1;
    step();
    chk("rst_drop_rvalid", {31'b0, o_rvalid}, 32'd0);
    chk("rst_drop_rdata", o_rdata, 32'h0);
    req = 1'b0; rst = 1'b0;
    wait_init(LAT);

`ifdef MEM_BANKED_CLEAR_EN
    // Reset in the middle of a clear sweep restarts it from row 0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 200; i++) step();
    chk("midclr_not_ready", {31'b0, o_init_done}, 32'd0);
    rst = 1'b1; step(); step(); rst = 1'b0;
    wait_init(512);
    m_op(11'h005, '0, 4'h0);
    chk("midclr_rd_5", o_rdata, 32'h0);
`else
    m_op(11'h005, '0, 4'h0);
    chk("post_rst_rd_5", o_rdata, 32'hDEADBEAA);
`endif

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
